// File: rtl/length_counter_bank.sv
// Bank of NCH APU length counters with enable, halt, status readback and a
// fixed or runtime-writable 32-entry length lookup table.
module length_counter_bank #(
    parameter int NCH          = 4,
    parameter int CW           = 8,
    parameter int TABLE_MODE   = 0,
    parameter int RELOAD_QUIRK = 1
) (
    input  logic           n_ACLK,
    input  logic           RES,
    input  logic [7:0]     DB,
    input  logic [NCH-1:0] W_load,
    input  logic           W4015,
    input  logic [NCH-1:0] ENA,
    input  logic           nLFO2,
    input  logic [NCH-1:0] HALT,
    input  logic           n_R4015,
    output logic [NCH-1:0] STAT,
    output logic [NCH-1:0] NotCount,
    input  logic           TBL_WE,
    input  logic [4:0]     TBL_ADDR,
    input  logic [CW-1:0]  TBL_DATA
);

    localparam logic QUIRK = (RELOAD_QUIRK != 0);

    function automatic logic [CW-1:0] fixed_len(input logic [4:0] idx);
        logic [7:0]    v;
        logic [CW+7:0] ext;
        case (idx)
            5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;   5'd3:  v = 8'd2;
            5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;   5'd7:  v = 8'd6;
            5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;   5'd11: v = 8'd10;
            5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;   5'd15: v = 8'd14;
            5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;   5'd19: v = 8'd18;
            5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;   5'd23: v = 8'd22;
            5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;   5'd27: v = 8'd26;
            5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;   default: v = 8'd30;
        endcase
        ext = {{CW{1'b0}}, v};
        return ext[CW-1:0];
    endfunction

    logic [CW-1:0] w_loadVal;

    // Registered table: a load in the same cycle as a write sees the old entry.
    if (TABLE_MODE != 0) begin : g_ram
        logic [CW-1:0] r_tbl [32];
        logic          w_unusedTbl;

        always_ff @(posedge n_ACLK) begin
            if (RES) begin
                for (int k = 0; k < 32; k++) r_tbl[k] <= fixed_len(5'(k));
            end else if (TBL_WE) begin
                r_tbl[TBL_ADDR] <= TBL_DATA;
            end
        end

        assign w_loadVal   = r_tbl[DB[7:3]];
        assign w_unusedTbl = &{1'b0, DB[2:0]};
    end else begin : g_rom
        logic w_unusedTbl;

        assign w_loadVal   = fixed_len(DB[7:3]);
        assign w_unusedTbl = &{1'b0, TBL_WE, TBL_ADDR, TBL_DATA, DB[2:0]};
    end

    logic [NCH-1:0]         r_ena;
    logic [NCH-1:0][CW-1:0] r_cnt;
    logic [NCH-1:0]         w_kill;
    logic [NCH-1:0]         w_enaNext;
    logic [NCH-1:0]         w_tick;
    logic [NCH-1:0]         w_load;

    assign w_kill    = {NCH{W4015}} & ~ENA;
    assign w_enaNext = W4015 ? ENA : r_ena;

    // With the quirk, a real decrement on a nonzero counter swallows a same-cycle load.
    always_comb begin
        w_tick = '0;
        for (int i = 0; i < NCH; i++) begin
            w_tick[i] = ~nLFO2 & ~HALT[i] & (r_cnt[i] != '0);
        end
        w_load = W_load & w_enaNext & ~(w_tick & {NCH{QUIRK}});
    end

    always_ff @(posedge n_ACLK) begin
        if (RES) begin
            r_ena <= '0;
            r_cnt <= '0;
        end else begin
            r_ena <= w_enaNext;
            for (int i = 0; i < NCH; i++) begin
                if (w_kill[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_load[i]) begin
                    r_cnt[i] <= w_loadVal;
                end else if (w_tick[i]) begin
                    r_cnt[i] <= r_cnt[i] - CW'(1);
                end
            end
        end
    end

    always_comb begin
        NotCount = '0;
        for (int i = 0; i < NCH; i++) begin
            NotCount[i] = (r_cnt[i] == '0);
        end
    end

    assign STAT = n_R4015 ? '0 : ~NotCount;

endmodule

// File: tb/tb_length_counter_bank.sv
// Directed bench for length_counter_bank: default bank, a RELOAD_QUIRK=0 twin,
// and a writable-table variant (NCH=6, CW=10), all observed through NotCount/STAT.
module tb_length_counter_bank;

    logic       clk = 1'b0;
    logic       res;
    logic [7:0] db;
    logic [3:0] wLoad;
    logic       w4015;
    logic [3:0] ena;
    logic       nLfo2;
    logic [3:0] halt;
    logic       nR4015;
    logic [3:0] stat, notCount, statNq, notCountNq;

    logic [5:0] wLoad6, ena6, halt6, stat6, notCount6;
    logic       tblWe;
    logic [4:0] tblAddr;
    logic [9:0] tblData;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    length_counter_bank dut (
        .n_ACLK(clk), .RES(res), .DB(db), .W_load(wLoad), .W4015(w4015), .ENA(ena),
        .nLFO2(nLfo2), .HALT(halt), .n_R4015(nR4015), .STAT(stat), .NotCount(notCount),
        .TBL_WE(1'b0), .TBL_ADDR(5'd0), .TBL_DATA(8'd0)
    );

    length_counter_bank #(.RELOAD_QUIRK(0)) dutNq (
        .n_ACLK(clk), .RES(res), .DB(db), .W_load(wLoad), .W4015(w4015), .ENA(ena),
        .nLFO2(nLfo2), .HALT(halt), .n_R4015(nR4015), .STAT(statNq), .NotCount(notCountNq),
        .TBL_WE(1'b0), .TBL_ADDR(5'd0), .TBL_DATA(8'd0)
    );

    length_counter_bank #(.NCH(6), .CW(10), .TABLE_MODE(1)) dutTb (
        .n_ACLK(clk), .RES(res), .DB(db), .W_load(wLoad6), .W4015(w4015), .ENA(ena6),
        .nLFO2(nLfo2), .HALT(halt6), .n_R4015(nR4015), .STAT(stat6), .NotCount(notCount6),
        .TBL_WE(tblWe), .TBL_ADDR(tblAddr), .TBL_DATA(tblData)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        res    = 1'b0;
        wLoad  = '0;
        wLoad6 = '0;
        w4015  = 1'b0;
        nLfo2  = 1'b1;
        tblWe  = 1'b0;
    endtask

    // One half-frame tick: nLFO2 low for a single cycle, then a quiet cycle.
    task automatic tick(input int n);
        repeat (n) begin
            nLfo2 = 1'b0;
            step();
            nLfo2 = 1'b1;
            step();
        end
    endtask

    task automatic test_reset();
        res = 1'b1; wLoad = 4'hF; w4015 = 1'b1; ena = 4'hF;
        step(); idle(); ena = 4'h0;
        total++; if (notCount !== 4'hF) begin bad++; $display("[TB] FAIL reset_notcount got=%h exp=%h", notCount, 4'hF); end
        total++; if (stat !== 4'h0) begin bad++; $display("[TB] FAIL reset_stat got=%h exp=%h", stat, 4'h0); end
        total++; if (notCount6 !== 6'h3F) begin bad++; $display("[TB] FAIL reset_notcount6 got=%h exp=%h", notCount6, 6'h3F); end
        wLoad = 4'h1; db = 8'h08;
        step(); idle(); step();
        total++; if (notCount[0] !== 1'b1) begin bad++; $display("[TB] FAIL load_while_disabled got=%b exp=1", notCount[0]); end
    endtask

    task automatic test_load_count();
        w4015 = 1'b1; ena = 4'h1;
        step(); idle();
        wLoad = 4'h1; db = 8'h08;
        step(); idle();
        total++; if (notCount !== 4'hE) begin bad++; $display("[TB] FAIL load_notcount got=%h exp=%h", notCount, 4'hE); end
        total++; if (stat !== 4'h1) begin bad++; $display("[TB] FAIL load_stat got=%h exp=%h", stat, 4'h1); end
        tick(253);
        total++; if (notCount[0] !== 1'b0) begin bad++; $display("[TB] FAIL count_253 got=%b exp=0", notCount[0]); end
        tick(1);
        total++; if (notCount[0] !== 1'b1) begin bad++; $display("[TB] FAIL count_254 got=%b exp=1", notCount[0]); end
        total++; if (stat[0] !== 1'b0) begin bad++; $display("[TB] FAIL count_254_stat got=%b exp=0", stat[0]); end
        tick(3);
        total++; if (notCount[0] !== 1'b1) begin bad++; $display("[TB] FAIL no_wrap got=%b exp=1", notCount[0]); end
    endtask

    task automatic test_halt();
        w4015 = 1'b1; ena = 4'h5;
        step(); idle();
        wLoad = 4'h4; db = 8'h18; halt = 4'h4;
        step(); idle();
        tick(10);
        total++; if (notCount[2] !== 1'b0) begin bad++; $display("[TB] FAIL halt_hold got=%b exp=0", notCount[2]); end
        halt = 4'h0;
        tick(1);
        total++; if (notCount[2] !== 1'b0) begin bad++; $display("[TB] FAIL halt_release1 got=%b exp=0", notCount[2]); end
        tick(1);
        total++; if (notCount[2] !== 1'b1) begin bad++; $display("[TB] FAIL halt_release2 got=%b exp=1", notCount[2]); end
    endtask

    task automatic test_disable();
        wLoad = 4'h1; db = 8'h40;
        step(); idle();
        tick(5);
        total++; if (stat[0] !== 1'b1) begin bad++; $display("[TB] FAIL dis_stat_before got=%b exp=1", stat[0]); end
        nR4015 = 1'b1;
        #1;
        total++; if (stat !== 4'h0) begin bad++; $display("[TB] FAIL stat_gated got=%h exp=%h", stat, 4'h0); end
        nR4015 = 1'b0;
        w4015 = 1'b1; ena = 4'h4; wLoad = 4'h1; db = 8'h08;
        #1;
        total++; if (stat[0] !== 1'b1) begin bad++; $display("[TB] FAIL stat_pre_write got=%b exp=1", stat[0]); end
        step(); idle();
        total++; if (notCount[0] !== 1'b1) begin bad++; $display("[TB] FAIL disable_notcount got=%b exp=1", notCount[0]); end
        total++; if (stat[0] !== 1'b0) begin bad++; $display("[TB] FAIL disable_stat got=%b exp=0", stat[0]); end
        wLoad = 4'h1;
        step(); idle(); step();
        total++; if (notCount[0] !== 1'b1) begin bad++; $display("[TB] FAIL load_after_disable got=%b exp=1", notCount[0]); end
    endtask

    task automatic test_quirk();
        w4015 = 1'b1; ena = 4'h2;
        step(); idle();
        wLoad = 4'h2; db = 8'h38;
        step(); idle();
        tick(1);
        nLfo2 = 1'b0; wLoad = 4'h2; db = 8'h00;
        step(); idle(); step();
        tick(3);
        total++; if (notCount[1] !== 1'b0) begin bad++; $display("[TB] FAIL quirk_nz_3 got=%b exp=0", notCount[1]); end
        tick(1);
        total++; if (notCount[1] !== 1'b1) begin bad++; $display("[TB] FAIL quirk_nz_4 got=%b exp=1", notCount[1]); end
        total++; if (notCountNq[1] !== 1'b0) begin bad++; $display("[TB] FAIL noquirk_4 got=%b exp=0", notCountNq[1]); end
        tick(5);
        total++; if (notCountNq[1] !== 1'b0) begin bad++; $display("[TB] FAIL noquirk_9 got=%b exp=0", notCountNq[1]); end
        tick(1);
        total++; if (notCountNq[1] !== 1'b1) begin bad++; $display("[TB] FAIL noquirk_10 got=%b exp=1", notCountNq[1]); end
        nLfo2 = 1'b0; wLoad = 4'h2; db = 8'h00;
        step(); idle(); step();
        tick(9);
        total++; if (notCount[1] !== 1'b0) begin bad++; $display("[TB] FAIL quirk_z_9 got=%b exp=0", notCount[1]); end
        total++; if (notCountNq[1] !== 1'b0) begin bad++; $display("[TB] FAIL noquirk_z_9 got=%b exp=0", notCountNq[1]); end
        tick(1);
        total++; if (notCount[1] !== 1'b1) begin bad++; $display("[TB] FAIL quirk_z_10 got=%b exp=1", notCount[1]); end
        total++; if (notCountNq[1] !== 1'b1) begin bad++; $display("[TB] FAIL noquirk_z_10 got=%b exp=1", notCountNq[1]); end
    endtask

    task automatic test_back_to_back();
        w4015 = 1'b1; ena = 4'h8;
        step(); idle();
        wLoad = 4'h8; db = 8'h18;
        step();
        db = 8'h08;
        step(); idle();
        tick(2);
        total++; if (notCount[3] !== 1'b0) begin bad++; $display("[TB] FAIL back_to_back got=%b exp=0", notCount[3]); end
        res = 1'b1; wLoad = 4'h8; w4015 = 1'b1; ena = 4'h8;
        step(); idle();
        total++; if (notCount !== 4'hF) begin bad++; $display("[TB] FAIL reset_mid_count got=%h exp=%h", notCount, 4'hF); end
        wLoad = 4'h8; db = 8'h08;
        step(); idle(); step();
        total++; if (notCount[3] !== 1'b1) begin bad++; $display("[TB] FAIL reset_clears_ena got=%b exp=1", notCount[3]); end
    endtask

    task automatic test_table();
        w4015 = 1'b1; ena = 4'h0; ena6 = 6'h20;
        step(); idle();
        tblWe = 1'b1; tblAddr = 5'd7; tblData = 10'd700; wLoad6 = 6'h20; db = 8'h38;
        step(); idle();
        total++; if (notCount6 !== 6'h1F) begin bad++; $display("[TB] FAIL tbl_old_load got=%h exp=%h", notCount6, 6'h1F); end
        tick(5);
        total++; if (notCount6[5] !== 1'b0) begin bad++; $display("[TB] FAIL tbl_old_5 got=%b exp=0", notCount6[5]); end
        tick(1);
        total++; if (notCount6[5] !== 1'b1) begin bad++; $display("[TB] FAIL tbl_old_6 got=%b exp=1", notCount6[5]); end
        wLoad6 = 6'h20; db = 8'h38;
        step(); idle();
        total++; if (stat6 !== 6'h20) begin bad++; $display("[TB] FAIL tbl_new_stat got=%h exp=%h", stat6, 6'h20); end
        tick(699);
        total++; if (notCount6[5] !== 1'b0) begin bad++; $display("[TB] FAIL tbl_new_699 got=%b exp=0", notCount6[5]); end
        tick(1);
        total++; if (notCount6[5] !== 1'b1) begin bad++; $display("[TB] FAIL tbl_new_700 got=%b exp=1", notCount6[5]); end
        res = 1'b1;
        step(); idle();
        w4015 = 1'b1; ena6 = 6'h20;
        step(); idle();
        wLoad6 = 6'h20; db = 8'h38;
        step(); idle();
        tick(5);
        total++; if (notCount6[5] !== 1'b0) begin bad++; $display("[TB] FAIL tbl_reset_5 got=%b exp=0", notCount6[5]); end
        tick(1);
        total++; if (notCount6[5] !== 1'b1) begin bad++; $display("[TB] FAIL tbl_reset_6 got=%b exp=1", notCount6[5]); end
    endtask

    initial begin
        idle();
        db = 8'h00; ena = 4'h0; halt = 4'h0; nR4015 = 1'b0;
        ena6 = 6'h0; halt6 = 6'h0; tblAddr = 5'd0; tblData = 10'd0;
        step();
        test_reset();
        test_load_count();
        test_halt();
        test_disable();
        test_quirk();
        test_back_to_back();
        test_table();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/length_counter_bank.md
# length_counter_bank

Parametrised bank of NCH APU length counters, the next generation of the fixed four-channel length-counter block. Each channel has an enable flag, a CW-bit down-counter loaded through a 32-entry length lookup (fixed 2A03 table or runtime-writable RAM), per-channel halt, and status readback. The bank sits between the register decoder ($4003/$4007/$400B/$400F, $4015) and the channel mixers, which gate their outputs with NotCount.

## Interface
Parameters:
- NCH, 4, number of channels (1..16)
- CW, 8, counter width; must be ≥ 8 when TABLE_MODE=0
- TABLE_MODE, 0, 0 = fixed 2A03 table; 1 = writable 32×CW table
- RELOAD_QUIRK, 1, 1 = a load coinciding with a tick on a nonzero counter is dropped; 0 = load always wins

Ports:
- n_ACLK  in  1  the single clock; all state updates on its rising edge
- RES  in  1  synchronous, active-high reset
- DB  in  8  write data; DB[7:3] is the length index on a load
- W_load  in  NCH  per-channel load strobe, one bit per channel
- W4015  in  1  enable-register write strobe
- ENA  in  NCH  enable bits, sampled when W4015=1
- nLFO2  in  1  active-low half-frame tick; low for exactly one cycle per tick
- HALT  in  NCH  per-channel halt (envelope-loop bit); 1 blocks decrement
- n_R4015  in  1  active-low status read enable
- STAT  out  NCH  status: bit i = (cnt[i]≠0) when n_R4015=0, else 0
- NotCount  out  NCH  bit i = (cnt[i]==0); the channel is silenced
- TBL_WE  in  1  table write strobe (ignored when TABLE_MODE=0)
- TBL_ADDR  in  5  table write address
- TBL_DATA  in  CW  table write data

## Operation
- Per-channel state: ena[i] (1 bit) and cnt[i] (CW bits).
- The fixed table (index 0..31) is 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30. Values are zero-extended to CW.
- In TABLE_MODE=1 the RAM resets to the fixed table. A write at TBL_ADDR takes effect on the next edge. A load in the same cycle reads the old entry.
- Per channel, per edge, the priority order is:
  1. RES: cnt=0, ena=0.
  2. W4015 with ENA[i]=0: ena=0 and cnt=0. This overrides a load and a tick in the same cycle.
  3. W4015 with ENA[i]=1: ena=1. Evaluation continues with the rules below.
  4. Load: W_load[i]=1 and ena=1 after step 3 gives cnt=table[DB[7:3]]. A load while disabled is ignored. Enable and load in the same cycle does load.
  5. Tick: nLFO2=0, HALT[i]=0 and cnt≠0 gives cnt=cnt−1. The counter saturates at 0 and never wraps.
- Load and tick in the same cycle:
  - RELOAD_QUIRK=1 and cnt≠0: the load is dropped and the decrement applies.
  - RELOAD_QUIRK=1 and cnt==0: the load wins.
  - RELOAD_QUIRK=0: the load always wins.
- HALT only freezes the counter. Load and disable still act while halted.
- STAT and NotCount are combinational from the registered cnt.

## Timing
- Reset values: cnt=0, ena=0, NotCount=all ones, STAT=0, table=fixed values.
- Load latency: NotCount[i] falls one edge after the W_load edge.
- Disable latency: NotCount[i] rises one edge after the W4015 edge.
- Tick latency: the decrement is visible one edge after the edge that sampled nLFO2=0. NotCount rises on the edge where cnt goes 1→0.
- Status read: zero latency (combinational on n_R4015). It reflects state before any same-cycle write.
- Back-to-back loads on consecutive cycles: the last one wins. No handshake and no stall.
- RES asserted mid-count clears everything on that edge. Writes in the same cycle are ignored.

## Test plan
- **Reset:** RES=1 for 1 cycle. Required: NotCount=4'hF, STAT=0 with n_R4015=0. Loads while ena=0 (W_load[0], DB=8'h08) leave NotCount[0]=1.
- **Load and count down:** W4015 ENA=4'h1; W_load[0], DB[7:3]=1 (value 254). Issue 253 ticks: cnt=1, NotCount[0]=0. On the 254th tick, NotCount[0]=1. Further ticks keep cnt=0 (no wrap).
- **Halt:** load channel 2 with index 3 (value 2), HALT[2]=1, 10 ticks → cnt stays 2. Release HALT, 2 ticks → NotCount[2]=1.
- **Disable:** disable during count (ENA bit 0 while cnt=100) → next edge cnt=0, STAT[0]=0. A load in the same cycle as the disable is also dropped.
- **Load-plus-tick, RELOAD_QUIRK=1:**
  - cnt=5, load index 0 with a tick → cnt=4.
  - cnt=0, load index 0 with a tick → cnt=10.
  - With RELOAD_QUIRK=0, cnt=5, load index 0 with a tick → cnt=10.
- **Writable table (TABLE_MODE=1, CW=10, NCH=6):**
  - TBL_WE addr 7, data 700; then load channel 5 index 7 → cnt=700, ticks decrement to 0.
  - A load in the same cycle as the table write returns old value 6.
